// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: bus widths, ALU operation and
// result-class codes, write-enable levels and a small absolute-value helper.
package ex_pkg;

  localparam int unsigned RegWidth    = 32;
  localparam int unsigned AluOpWidth  = 8;
  localparam int unsigned AluSelWidth = 3;

  typedef logic [RegWidth-1:0]    reg_bus_t;
  typedef logic [AluOpWidth-1:0]  alu_op_bus_t;
  typedef logic [AluSelWidth-1:0] alu_sel_bus_t;

  localparam logic     WriteEnable  = 1'b1;
  localparam logic     WriteDisable = 1'b0;
  localparam reg_bus_t ZeroWord     = 32'h0000_0000;
  localparam logic     RstEnable    = 1'b1;

  // Operation codes (aluop_i)
  localparam alu_op_bus_t AluOpNop  = 8'h00;
  localparam alu_op_bus_t AluOpOr   = 8'h25;
  localparam alu_op_bus_t AluOpAnd  = 8'h24;
  localparam alu_op_bus_t AluOpXor  = 8'h26;
  localparam alu_op_bus_t AluOpLui  = 8'h0f;
  localparam alu_op_bus_t AluOpAdd  = 8'h20;
  localparam alu_op_bus_t AluOpSub  = 8'h22;
  localparam alu_op_bus_t AluOpSlt  = 8'h2a;
  localparam alu_op_bus_t AluOpSltu = 8'h2b;
  localparam alu_op_bus_t AluOpSll  = 8'h7c;
  localparam alu_op_bus_t AluOpSrl  = 8'h02;
  localparam alu_op_bus_t AluOpSra  = 8'h03;
  localparam alu_op_bus_t AluOpMul  = 8'h18;
  localparam alu_op_bus_t AluOpMulh = 8'h19;

  // Result classes (alusel_i)
  localparam alu_sel_bus_t AluSelNop   = 3'd0;
  localparam alu_sel_bus_t AluSelLogic = 3'd1;
  localparam alu_sel_bus_t AluSelShift = 3'd2;
  localparam alu_sel_bus_t AluSelArith = 3'd4;
  localparam alu_sel_bus_t AluSelMul   = 3'd5;
  localparam alu_sel_bus_t AluSelMulh  = 3'd6;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic reg_bus_t abs32(input reg_bus_t v);
    return v[RegWidth-1] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst   : clock, synchronous active-high reset (abandons any operation)
//   start      : multiply request, accepted only while idle
//   signed_op  : 1 = signed operands (magnitudes multiplied, sign applied at end)
//   a, b       : multiplicand, multiplier; sampled only on the accepting cycle
//   busy       : iterating (32 cycles)
//   done       : product valid this cycle; returns to idle next cycle
//   product    : 64-bit result, meaningful while done
module ex_mul_iter
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {32'h0, signed_op ? abs32(a) : a};
          mplier_d = signed_op ? abs32(b) : b;
          neg_d    = signed_op & (a[31] ^ b[31]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      // Always leave DONE so a held instruction is never multiplied twice.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy    = (state_q == StBusy);
  assign done    = (state_q == StDone);
  assign product = neg_q ? (~acc_q + 64'd1) : acc_q;

endmodule

// File: rtl/ex.sv
// Execute stage of the RV32IM pipeline.
//   clk, rst    : clock, synchronous active-high reset (outputs forced to 0)
//   aluop_i     : operation code from ID/EX
//   alusel_i    : result class (NOP, LOGIC, SHIFT, ARITH, MUL, MULH)
//   reg1_i/2_i  : operands
//   wd_i/wreg_i : destination register / write enable
//   wd_o/wreg_o : destination to EX/MEM and the decode forwarding path
//   wdata_o     : result
//   stallreq_o  : hold PC, IF/ID and ID/EX while a multiply is in flight
module ex
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  logic        is_mul;
  logic        is_mulh;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_product;
  logic        stall;
  logic [4:0]  shamt;
  reg_bus_t    logic_res;
  reg_bus_t    shift_res;
  reg_bus_t    arith_res;
  reg_bus_t    result;

  assign is_mulh = (alusel_i == AluSelMulh);
  assign is_mul  = (alusel_i == AluSelMul) | is_mulh;
  assign shamt   = reg2_i[4:0];

  ex_mul_iter u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (is_mul),
    .signed_op (is_mulh),
    .a         (reg1_i),
    .b         (reg2_i),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (mul_product)
  );

  // Stall from the first cycle a multiply is seen until its DONE cycle.
  assign stall = mul_busy | (is_mul & ~mul_done);

  always_comb begin
    logic_res = ZeroWord;
    unique case (aluop_i)
      AluOpOr:  logic_res = reg1_i | reg2_i;
      AluOpAnd: logic_res = reg1_i & reg2_i;
      AluOpXor: logic_res = reg1_i ^ reg2_i;
      AluOpLui: logic_res = reg1_i;
      default:  logic_res = ZeroWord;
    endcase
  end

  always_comb begin
    shift_res = ZeroWord;
    unique case (aluop_i)
      AluOpSll: shift_res = reg1_i << shamt;
      AluOpSrl: shift_res = reg1_i >> shamt;
      AluOpSra: shift_res = reg_bus_t'($signed(reg1_i) >>> shamt);
      default:  shift_res = ZeroWord;
    endcase
  end

  always_comb begin
    arith_res = ZeroWord;
    unique case (aluop_i)
      AluOpAdd:  arith_res = reg1_i + reg2_i;
      AluOpSub:  arith_res = reg1_i - reg2_i;
      AluOpSlt:  arith_res = {31'h0, $signed(reg1_i) < $signed(reg2_i)};
      AluOpSltu: arith_res = {31'h0, reg1_i < reg2_i};
      default:   arith_res = ZeroWord;
    endcase
  end

  always_comb begin
    result = ZeroWord;
    case (alusel_i)
      AluSelLogic: result = logic_res;
      AluSelShift: result = shift_res;
      AluSelArith: result = arith_res;
      AluSelMul:   result = mul_done ? mul_product[31:0] : ZeroWord;
      AluSelMulh:  result = mul_done ? mul_product[63:32] : ZeroWord;
      default:     result = ZeroWord;
    endcase
  end

  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = WriteDisable;
    wdata_o    = ZeroWord;
    stallreq_o = 1'b0;
    if (rst != RstEnable) begin
      wd_o       = wd_i;
      // Suppress forwarding of a partial product while stalled.
      wreg_o     = wreg_i & ~stall;
      wdata_o    = result;
      stallreq_o = stall;
    end
  end

endmodule
